// File: rtl/pgm_rom_ddram_writer.sv
// pgm_rom_ddram_writer: packs 16-bit ioctl ROM words into 64-bit DDRAM beats.
// A one-entry skid register holds a word that arrives while a beat is being launched
// or written. ioctl_wait holds off hps_io until the skid register is empty again.
module pgm_rom_ddram_writer #(
    parameter logic [7:0]  ROM_INDEX = 8'd0,
    parameter logic [28:0] BASE_ADDR = 29'h0300000
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    input  logic        DDRAM_BUSY,
    output logic [28:0] DDRAM_ADDR,
    output logic [3:0]  DDRAM_BURSTCNT,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        rom_loaded
);

    localparam int unsigned AW  = 29;   // DDRAM beat address width
    localparam int unsigned DW  = 64;   // beat data width
    localparam int unsigned MW  = 8;    // byte-enable width
    localparam int unsigned WW  = 16;   // ioctl word width
    localparam int unsigned WAW = 26;   // ioctl word address width

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            dl_q;
    logic [DW-1:0]   buf_q;
    logic [MW-1:0]   mask_q;
    logic [AW-1:0]   addr_q;
    logic            skid_q;
    logic [WAW-1:0]  skid_a_q;
    logic [WW-1:0]   skid_d_q;
    logic            we_q;
    logic            wait_q;
    logic            loaded_q;
    logic [AW-1:0]   ddr_addr_q;
    logic [DW-1:0]   ddr_din_q;
    logic [MW-1:0]   ddr_be_q;

    logic            acc_c;
    logic [WAW-1:0]  in_a_c;
    logic [WW-1:0]   in_d_c;
    logic [AW-1:0]   in_beat_c;
    logic [1:0]      in_lane_c;
    logic [DW-1:0]   merge_buf_c;
    logic [MW-1:0]   merge_mask_c;
    logic            unused_addr0_c;

    // Byte address bit 0 is always zero for word transfers
    assign unused_addr0_c = ioctl_addr[0];

    assign acc_c     = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
    // A parked skid word is always older than a live strobe, so it is consumed first
    assign in_a_c    = skid_q ? skid_a_q : ioctl_addr[26:1];
    assign in_d_c    = skid_q ? skid_d_q : ioctl_dout;
    assign in_beat_c = BASE_ADDR + AW'(in_a_c[WAW-1:2]);
    assign in_lane_c = in_a_c[1:0];

    // Held beat with the incoming word merged into its lane
    always_comb begin
        merge_buf_c  = buf_q;
        merge_mask_c = mask_q;
        merge_buf_c[{in_lane_c, 4'b0000} +: WW] = in_d_c;
        merge_mask_c[{in_lane_c, 1'b0} +: 2]    = 2'b11;
    end

    // Download sequencer, beat buffer, skid register and registered DDRAM outputs
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b0;
            buf_q      <= '0;
            mask_q     <= '0;
            addr_q     <= '0;
            skid_q     <= 1'b0;
            skid_a_q   <= '0;
            skid_d_q   <= '0;
            we_q       <= 1'b0;
            wait_q     <= 1'b0;
            loaded_q   <= 1'b0;
            ddr_addr_q <= '0;
            ddr_din_q  <= '0;
            ddr_be_q   <= '0;
        end else begin
            dl_q <= ioctl_download;
            case (state_q)
                S_IDLE: begin
                    wait_q <= 1'b0;
                    if (ioctl_download && !dl_q && (ioctl_index == ROM_INDEX)) begin
                        state_q  <= S_COLLECT;
                        loaded_q <= 1'b0;
                        buf_q    <= '0;
                        mask_q   <= '0;
                        skid_q   <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (!ioctl_download && !skid_q) begin
                        // Download over: write any partial beat, then finish
                        if (mask_q != '0) begin
                            we_q       <= 1'b1;
                            ddr_addr_q <= addr_q;
                            ddr_din_q  <= buf_q;
                            ddr_be_q   <= mask_q;
                            state_q    <= S_FLUSH;
                            wait_q     <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            wait_q  <= 1'b0;
                        end
                    end else if (skid_q || acc_c) begin
                        if ((mask_q != '0) && (in_beat_c != addr_q)) begin
                            // Word belongs to another beat: launch the held one, park the word
                            we_q       <= 1'b1;
                            ddr_addr_q <= addr_q;
                            ddr_din_q  <= buf_q;
                            ddr_be_q   <= mask_q;
                            state_q    <= S_WRITE;
                            wait_q     <= 1'b1;
                            if (!skid_q) begin
                                skid_q   <= 1'b1;
                                skid_a_q <= ioctl_addr[26:1];
                                skid_d_q <= ioctl_dout;
                            end
                        end else begin
                            buf_q  <= merge_buf_c;
                            mask_q <= merge_mask_c;
                            addr_q <= in_beat_c;
                            if (skid_q) begin
                                skid_q <= acc_c;
                                if (acc_c) begin
                                    skid_a_q <= ioctl_addr[26:1];
                                    skid_d_q <= ioctl_dout;
                                end
                            end
                            if (in_lane_c == 2'd3) begin
                                we_q       <= 1'b1;
                                ddr_addr_q <= in_beat_c;
                                ddr_din_q  <= merge_buf_c;
                                ddr_be_q   <= merge_mask_c;
                                state_q    <= S_WRITE;
                                wait_q     <= 1'b1;
                            end else begin
                                wait_q <= skid_q & acc_c;
                            end
                        end
                    end else begin
                        wait_q <= 1'b0;
                    end
                end
                S_WRITE, S_FLUSH: begin
                    if (acc_c && !skid_q) begin
                        skid_q   <= 1'b1;
                        skid_a_q <= ioctl_addr[26:1];
                        skid_d_q <= ioctl_dout;
                    end
                    if (!DDRAM_BUSY) begin
                        // Beat accepted: drop WE and start a fresh buffer
                        we_q    <= 1'b0;
                        buf_q   <= '0;
                        mask_q  <= '0;
                        state_q <= (state_q == S_FLUSH) ? S_DONE : S_COLLECT;
                        wait_q  <= skid_q | acc_c;
                    end
                end
                S_DONE: begin
                    loaded_q <= 1'b1;
                    wait_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ioctl_wait     = wait_q;
    assign DDRAM_WE       = we_q;
    assign DDRAM_ADDR     = ddr_addr_q;
    assign DDRAM_DIN      = ddr_din_q;
    assign DDRAM_BE       = ddr_be_q;
    assign DDRAM_BURSTCNT = 4'd1;
    assign rom_loaded     = loaded_q;

endmodule

// File: tb/tb_pgm_rom_ddram_writer.sv
// Directed bench for pgm_rom_ddram_writer: drives ioctl downloads, logs accepted DDRAM beats.
module tb_pgm_rom_ddram_writer;

    localparam logic [28:0] BASE = 29'h0300000;

    logic        CLK_50M = 1'b0;
    logic        RESET = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic        DDRAM_BUSY = 1'b0;
    logic [28:0] DDRAM_ADDR;
    logic [3:0]  DDRAM_BURSTCNT;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic        rom_loaded;

    int n_assert = 0;
    int n_fail = 0;

    logic [28:0] q_addr[$];
    logic [63:0] q_din[$];
    logic [7:0]  q_be[$];

    pgm_rom_ddram_writer #(
        .ROM_INDEX(8'd0),
        .BASE_ADDR(BASE)
    ) dut (
        .CLK_50M(CLK_50M),
        .RESET(RESET),
        .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait),
        .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_DIN(DDRAM_DIN),
        .DDRAM_BE(DDRAM_BE),
        .DDRAM_WE(DDRAM_WE),
        .rom_loaded(rom_loaded)
    );

    always #5 CLK_50M = ~CLK_50M;

    // Log every beat the DDRAM side accepts
    always @(posedge CLK_50M) begin
        if (!RESET && DDRAM_WE && !DDRAM_BUSY) begin
            q_addr.push_back(DDRAM_ADDR);
            q_din.push_back(DDRAM_DIN);
            q_be.push_back(DDRAM_BE);
        end
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK_50M);
            #1;
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_din.delete();
        q_be.delete();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        cyc(2);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        cyc(8);
    endtask

    // One ioctl word, honouring ioctl_wait with a bounded stall
    task automatic send(input logic [26:0] a, input logic [15:0] d);
        int guard;
        guard = 0;
        while (ioctl_wait !== 1'b0 && guard < 100) begin
            cyc(1);
            guard++;
        end
        check("wait_bound", 64'(guard >= 100), 64'd0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
        cyc(1);
    endtask

    initial begin
        // Reset values
        RESET = 1'b1;
        cyc(3);
        check("rst_we", 64'(DDRAM_WE), 64'd0);
        check("rst_wait", 64'(ioctl_wait), 64'd0);
        check("rst_addr", 64'(DDRAM_ADDR), 64'd0);
        check("rst_din", DDRAM_DIN, 64'd0);
        check("rst_be", 64'(DDRAM_BE), 64'd0);
        check("rst_loaded", 64'(rom_loaded), 64'd0);
        check("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        RESET = 1'b0;
        cyc(2);

        // Foreign index is ignored
        clear_log();
        start_dl(8'd1);
        for (int i = 0; i < 16; i++) send(27'(2 * i), 16'hDEAD ^ 16'(i));
        end_dl();
        check("idx_we_count", 64'(q_addr.size()), 64'd0);
        check("idx_loaded", 64'(rom_loaded), 64'd0);

        // Eight words -> two full beats
        clear_log();
        start_dl(8'd0);
        for (int n = 0; n < 8; n++) send(27'(2 * n), 16'(n * 16'h1111));
        end_dl();
        check("full_count", 64'(q_addr.size()), 64'd2);
        check("full_addr0", 64'(q_addr[0]), 64'(BASE));
        check("full_addr1", 64'(q_addr[1]), 64'(BASE + 29'd1));
        check("full_be0", 64'(q_be[0]), 64'hFF);
        check("full_be1", 64'(q_be[1]), 64'hFF);
        check("full_din0_lo", 64'(q_din[0][15:0]), 64'h0000);
        check("full_din1_lo", 64'(q_din[1][15:0]), 64'h4444);
        check("full_din0", q_din[0], 64'h3333_2222_1111_0000);
        check("full_din1", q_din[1], 64'h7777_6666_5555_4444);
        check("full_loaded", 64'(rom_loaded), 64'd1);

        // Partial beat flushed at download end
        clear_log();
        start_dl(8'd0);
        check("part_loaded_clr", 64'(rom_loaded), 64'd0);
        send(27'd0, 16'hA001);
        send(27'd2, 16'hA002);
        send(27'd4, 16'hA003);
        end_dl();
        check("part_count", 64'(q_addr.size()), 64'd1);
        check("part_addr", 64'(q_addr[0]), 64'(BASE));
        check("part_be", 64'(q_be[0]), 64'h3F);
        check("part_din_hi", 64'(q_din[0][63:48]), 64'd0);
        check("part_din", q_din[0], 64'h0000_A003_A002_A001);
        check("part_loaded", 64'(rom_loaded), 64'd1);

        // DDRAM busy for ten cycles on the first beat
        clear_log();
        DDRAM_BUSY = 1'b1;
        start_dl(8'd0);
        for (int n = 0; n < 4; n++) send(27'(2 * n), 16'hB000 + 16'(n));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("busy_we_%0d", i), 64'(DDRAM_WE), 64'd1);
            check($sformatf("busy_addr_%0d", i), 64'(DDRAM_ADDR), 64'(BASE));
            check($sformatf("busy_din_%0d", i), DDRAM_DIN, 64'hB003_B002_B001_B000);
            check($sformatf("busy_wait_%0d", i), 64'(ioctl_wait), 64'd1);
            cyc(1);
        end
        DDRAM_BUSY = 1'b0;
        cyc(1);
        check("busy_we_drop", 64'(DDRAM_WE), 64'd0);
        check("busy_wait_drop", 64'(ioctl_wait), 64'd0);
        check("busy_accepts", 64'(q_addr.size()), 64'd1);
        end_dl();
        check("busy_accepts_end", 64'(q_addr.size()), 64'd1);
        check("busy_loaded", 64'(rom_loaded), 64'd1);

        // Beat change lands the second word in the skid register
        clear_log();
        start_dl(8'd0);
        send(27'd0, 16'hC0C0);
        ioctl_addr = 27'h100;
        ioctl_dout = 16'hC1C1;
        ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
        check("skid_launch_we", 64'(DDRAM_WE), 64'd1);
        check("skid_launch_addr", 64'(DDRAM_ADDR), 64'(BASE));
        check("skid_launch_be", 64'(DDRAM_BE), 64'h03);
        check("skid_wait_hi", 64'(ioctl_wait), 64'd1);
        cyc(3);
        check("skid_wait_lo", 64'(ioctl_wait), 64'd0);
        end_dl();
        check("skid_count", 64'(q_addr.size()), 64'd2);
        check("skid_addr0", 64'(q_addr[0]), 64'(BASE));
        check("skid_be0", 64'(q_be[0]), 64'h03);
        check("skid_din0", q_din[0], 64'h0000_0000_0000_C0C0);
        check("skid_addr1", 64'(q_addr[1]), 64'(BASE + 29'h20));
        check("skid_be1", 64'(q_be[1]), 64'h03);
        check("skid_din1", q_din[1], 64'h0000_0000_0000_C1C1);

        // Reset while a write is stalled drops the beat
        clear_log();
        DDRAM_BUSY = 1'b1;
        start_dl(8'd0);
        for (int n = 0; n < 4; n++) send(27'(2 * n), 16'hD000 + 16'(n));
        check("mid_we_pre", 64'(DDRAM_WE), 64'd1);
        RESET = 1'b1;
        ioctl_download = 1'b0;
        cyc(1);
        check("mid_we", 64'(DDRAM_WE), 64'd0);
        check("mid_wait", 64'(ioctl_wait), 64'd0);
        check("mid_loaded", 64'(rom_loaded), 64'd0);
        check("mid_addr", 64'(DDRAM_ADDR), 64'd0);
        check("mid_be", 64'(DDRAM_BE), 64'd0);
        RESET = 1'b0;
        DDRAM_BUSY = 1'b0;
        cyc(5);
        check("mid_no_accept", 64'(q_addr.size()), 64'd0);
        check("mid_we_idle", 64'(DDRAM_WE), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
